// File: rtl/me2_redirect_ctrl.sv
// ME2 branch-redirect controller: registers a taken branch as a handshaked
// fetch redirect and holds flush through a programmable drain window.
module me2_redirect_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              me2_valid,
    input  logic              me2_pcsrc,
    input  logic [ADDR_W-1:0] me2_target,
    output logic              fe_redirect_valid,
    output logic [ADDR_W-1:0] fe_redirect_pc,
    input  logic              fe_redirect_ready,
    output logic              flush,
    output logic              busy,
    output logic [CNT_W-1:0]  redirect_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] DRAIN_INIT =
        4'((FLUSH_CYCLES == 0) ? 0 : FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic [3:0]        drain_cnt;
    logic [ADDR_W-1:0] pc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              valid_q;
    logic              flush_q;
    logic              busy_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            drain_cnt <= 4'd0;
            pc_q      <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            flush_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (me2_valid && me2_pcsrc) begin
                        pc_q    <= {me2_target[ADDR_W-1:1], 1'b0};
                        state   <= REQ;
                        valid_q <= 1'b1;
                        flush_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                REQ: begin
                    // ME2 inputs are wrong-path here and deliberately ignored
                    if (fe_redirect_ready) begin
                        cnt_q   <= cnt_q + CNT_ONE;
                        valid_q <= 1'b0;
                        if (FLUSH_CYCLES == 0) begin
                            state   <= IDLE;
                            flush_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end else begin
                            drain_cnt <= DRAIN_INIT;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 4'd0) begin
                        state   <= IDLE;
                        flush_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt - 4'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    flush_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fe_redirect_valid = valid_q;
    assign fe_redirect_pc    = pc_q;
    assign flush             = flush_q;
    assign busy              = busy_q;
    assign redirect_count    = cnt_q;

endmodule
